// File: rtl/obstacle_spawn_scheduler_pkg.sv
// Shared types and constants for the obstacle spawn scheduler and the game datapath.
package obstacle_spawn_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } sched_state_e;

  localparam logic [15:0] LFSR_MASK = 16'hB400;

  // Screen geometry shared with the renderer and collision check.
  localparam int X_MAX      = 160;
  localparam int GROUND_TOP = 100;
  localparam int OBS_W      = 8;

  function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
    lfsr_next = cur[0] ? ((cur >> 1) ^ LFSR_MASK) : (cur >> 1);
  endfunction

endpackage

// File: rtl/obstacle_spawn_scheduler_lfsr16.sv
// 16-bit Galois LFSR, free-running except while reset is held.
module lfsr16
  import obstacle_spawn_scheduler_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] q
);

  logic [15:0] q_q;
  logic [15:0] q_d;

  always_comb begin
    q_d = lfsr_next(q_q);
  end

  always_ff @(posedge clk) begin
    if (reset) q_q <= SEED;
    else       q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/obstacle_spawn_scheduler.sv
// Obstacle slot mover / retirer / respawner driven by obs_tick while RUN.
// Optional passed-dino pulse is built only when OBS_PASS_PULSE_EN is defined.
module obstacle_spawn_scheduler
  import obstacle_spawn_scheduler_pkg::*;
#(
  parameter int          NUM_OBS   = 2,
  parameter int          SPAWN_X   = X_MAX,
  parameter int          MIN_GAP   = 40,
  parameter int          FIRST_GAP = 0,
  parameter int          MIN_H     = 7,
  parameter int          DINO_X    = 15,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   enable,
  input  logic                   obs_tick,
  input  logic [1:0]             speed,
  output logic [8*NUM_OBS-1:0]   obs_x,
  output logic [8*NUM_OBS-1:0]   obs_h,
  output logic [NUM_OBS-1:0]     obs_active,
  output logic                   spawn_pulse,
  output logic                   passed_pulse
);

  localparam int unused_geom = GROUND_TOP + OBS_W;

  sched_state_e       state_q, state_d;
  logic [7:0]         x_q [NUM_OBS];
  logic [7:0]         x_d [NUM_OBS];
  logic [7:0]         h_q [NUM_OBS];
  logic [7:0]         h_d [NUM_OBS];
  logic [NUM_OBS-1:0] active_q, active_d;
  logic [7:0]         gap_q, gap_d;
  logic               spawn_q, spawn_d;

  logic [15:0]        lfsr_q;
  logic [6:0]         unused_lfsr_hi;
  logic [7:0]         step;
  logic               tick_act;
  logic [NUM_OBS-1:0] retire;
  logic [NUM_OBS-1:0] free_slot;
  logic [NUM_OBS-1:0] spawn_sel;
  logic [7:0]         moved_x [NUM_OBS];

  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .q     (lfsr_q)
  );

  assign unused_lfsr_hi = lfsr_q[15:9];

  assign step     = (speed == 2'd0) ? 8'd1 : {6'd0, speed};
  assign tick_act = obs_tick && !clear && (state_q == ST_RUN);

  for (genvar gi = 0; gi < NUM_OBS; gi++) begin : g_slot
    assign retire[gi]        = active_q[gi] && (x_q[gi] < step);
    assign free_slot[gi]     = !active_q[gi] || retire[gi];
    assign moved_x[gi]       = x_q[gi] - step;
    assign obs_x[8*gi +: 8]  = x_q[gi];
    assign obs_h[8*gi +: 8]  = h_q[gi];
  end

  // Lowest-index free slot, only when the gap has run out on an acted tick.
  always_comb begin
    spawn_sel = '0;
    if (tick_act && (gap_q == 8'd0)) begin
      for (int i = NUM_OBS - 1; i >= 0; i--) begin
        if (free_slot[i]) begin
          spawn_sel    = '0;
          spawn_sel[i] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    h_d      = h_q;
    active_d = active_q;
    gap_d    = gap_q;
    spawn_d  = 1'b0;

    if (clear) begin
      state_d  = ST_IDLE;
      active_d = '0;
      gap_d    = 8'(FIRST_GAP);
    end else begin
      case (state_q)
        ST_IDLE: if (enable)  state_d = ST_RUN;
        ST_RUN:  if (!enable) state_d = ST_HOLD;
        ST_HOLD: if (enable)  state_d = ST_RUN;
        default:              state_d = ST_IDLE;
      endcase

      if (tick_act) begin
        gap_d = (gap_q <= step) ? 8'd0 : gap_q - step;
        for (int i = 0; i < NUM_OBS; i++) begin
          if (spawn_sel[i]) begin
            x_d[i]      = 8'(SPAWN_X);
            h_d[i]      = 8'(MIN_H) + {5'd0, lfsr_q[2:0]};
            active_d[i] = 1'b1;
            gap_d       = 8'(MIN_GAP) + {2'd0, lfsr_q[8:3]};
            spawn_d     = 1'b1;
          end else if (retire[i]) begin
            active_d[i] = 1'b0;
          end else if (active_q[i]) begin
            x_d[i] = moved_x[i];
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      x_q      <= '{default: 8'd0};
      h_q      <= '{default: 8'd0};
      active_q <= '0;
      gap_q    <= 8'(FIRST_GAP);
      spawn_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      h_q      <= h_d;
      active_q <= active_d;
      gap_q    <= gap_d;
      spawn_q  <= spawn_d;
    end
  end

  assign obs_active  = active_q;
  assign spawn_pulse = spawn_q;

`ifdef OBS_PASS_PULSE_EN
  logic [NUM_OBS-1:0] pflag_q, pflag_d;
  logic               passed_q, passed_d;

  // Flag is set once per slot lifetime; retiring slots never report a pass.
  always_comb begin
    pflag_d  = pflag_q;
    passed_d = 1'b0;
    if (tick_act) begin
      for (int i = 0; i < NUM_OBS; i++) begin
        if (spawn_sel[i]) begin
          pflag_d[i] = 1'b0;
        end else if (active_q[i] && !retire[i] && !pflag_q[i] &&
                     (moved_x[i] < 8'(DINO_X))) begin
          pflag_d[i] = 1'b1;
          passed_d   = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pflag_q  <= '0;
      passed_q <= 1'b0;
    end else begin
      pflag_q  <= pflag_d;
      passed_q <= passed_d;
    end
  end

  assign passed_pulse = passed_q;
`else
  logic [7:0] unused_dino_x;
  assign unused_dino_x = 8'(DINO_X);
  assign passed_pulse  = 1'b0;
`endif

endmodule

// File: tb/tb_obstacle_spawn_scheduler.sv
// Directed bench: two DUT instances (2 slots / 1 slot with short gap) against a slot-level model.
module tb_obstacle_spawn_scheduler;

  localparam int IDLE = 0, RUN = 1, HOLD = 2;
`ifdef OBS_PASS_PULSE_EN
  localparam bit PP_ON = 1'b1;
`else
  localparam bit PP_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, clear, enable, obs_tick;
  logic [1:0]  speed;
  logic [15:0] x0, h0;
  logic [1:0]  a0;
  logic        sp0, pp0;
  logic [7:0]  x1, h1;
  logic [0:0]  a1;
  logic        sp1, pp1;

  int n_err = 0;
  int n_chk = 0;
  int n_sp1 = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  obstacle_spawn_scheduler #(.NUM_OBS(2)) u_dut0 (
    .clk(clk), .reset(reset), .clear(clear), .enable(enable), .obs_tick(obs_tick),
    .speed(speed), .obs_x(x0), .obs_h(h0), .obs_active(a0),
    .spawn_pulse(sp0), .passed_pulse(pp0)
  );

  obstacle_spawn_scheduler #(.NUM_OBS(1), .MIN_GAP(8)) u_dut1 (
    .clk(clk), .reset(reset), .clear(clear), .enable(enable), .obs_tick(obs_tick),
    .speed(speed), .obs_x(x1), .obs_h(h1), .obs_active(a1),
    .spawn_pulse(sp1), .passed_pulse(pp1)
  );

  // Model state, indexed [instance][slot].
  int          nobs [2] = '{2, 1};
  int          mgap [2] = '{40, 8};
  int          m_st [2];
  int          m_x  [2][4];
  int          m_h  [2][4];
  bit          m_act[2][4];
  bit          m_pf [2][4];
  int          m_gap[2];
  bit          m_sp [2];
  bit          m_pp [2];
  logic [15:0] m_lfsr;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_step(input int k);
    int stp, old_gap, slot;
    m_sp[k] = 1'b0;
    m_pp[k] = 1'b0;
    if (reset) begin
      m_st[k] = IDLE;
      m_gap[k] = 0;
      for (int s = 0; s < 4; s++) begin
        m_x[k][s] = 0; m_h[k][s] = 0; m_act[k][s] = 1'b0; m_pf[k][s] = 1'b0;
      end
      return;
    end
    if (clear) begin
      m_st[k] = IDLE;
      m_gap[k] = 0;
      for (int s = 0; s < 4; s++) m_act[k][s] = 1'b0;
      return;
    end
    if (m_st[k] == RUN && obs_tick) begin
      stp = (speed == 0) ? 1 : int'(speed);
      old_gap = m_gap[k];
      for (int s = 0; s < nobs[k]; s++) begin
        if (m_act[k][s]) begin
          if (m_x[k][s] < stp) m_act[k][s] = 1'b0;
          else begin
            m_x[k][s] -= stp;
            if (PP_ON && !m_pf[k][s] && m_x[k][s] < 15) begin
              m_pf[k][s] = 1'b1;
              m_pp[k] = 1'b1;
            end
          end
        end
      end
      m_gap[k] = (m_gap[k] > stp) ? m_gap[k] - stp : 0;
      if (old_gap == 0) begin
        slot = -1;
        for (int s = 0; s < nobs[k]; s++) if (!m_act[k][s] && slot < 0) slot = s;
        if (slot >= 0) begin
          m_act[k][slot] = 1'b1;
          m_x[k][slot]   = 160;
          m_h[k][slot]   = 7 + int'(m_lfsr[2:0]);
          m_gap[k]       = mgap[k] + int'(m_lfsr[8:3]);
          m_pf[k][slot]  = 1'b0;
          m_sp[k]        = 1'b1;
        end
      end
    end
    case (m_st[k])
      IDLE:    if (enable)  m_st[k] = RUN;
      RUN:     if (!enable) m_st[k] = HOLD;
      default: if (enable)  m_st[k] = RUN;
    endcase
  endtask

  always @(posedge clk) begin
    model_step(0);
    model_step(1);
    if (reset) m_lfsr = 16'hACE1;
    else if (m_lfsr[0]) m_lfsr = (m_lfsr >> 1) ^ 16'hB400;
    else m_lfsr = m_lfsr >> 1;
  end

  // Cycle-by-cycle compare of both instances against the model.
  always @(negedge clk) begin
    logic [15:0] ex0, eh0;
    logic [1:0]  ea0;
    if (chk_en) begin
      for (int s = 0; s < 2; s++) begin
        ex0[8*s +: 8] = m_x[0][s][7:0];
        eh0[8*s +: 8] = m_h[0][s][7:0];
        ea0[s]        = m_act[0][s];
      end
      chk("d0_x", 32'(x0), 32'(ex0));
      chk("d0_h", 32'(h0), 32'(eh0));
      chk("d0_active", 32'(a0), 32'(ea0));
      chk("d0_spawn", 32'(sp0), 32'(m_sp[0]));
      chk("d0_passed", 32'(pp0), 32'(m_pp[0]));
      chk("d1_x", 32'(x1), 32'(m_x[1][0][7:0]));
      chk("d1_h", 32'(h1), 32'(m_h[1][0][7:0]));
      chk("d1_active", 32'(a1), 32'(m_act[1][0]));
      chk("d1_spawn", 32'(sp1), 32'(m_sp[1]));
      chk("d1_passed", 32'(pp1), 32'(m_pp[1]));
      if (sp1) n_sp1++;
    end
  end

  task automatic tick();
    obs_tick = 1'b1;
    @(negedge clk);
    obs_tick = 1'b0;
  endtask

  task automatic tick_gap(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      @(negedge clk);
    end
  endtask

  initial begin
    reset = 1'b1; clear = 1'b0; enable = 1'b0; obs_tick = 1'b0; speed = 2'd1;
    @(negedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    chk("rst_active", 32'(a0), 32'd0);
    chk("rst_x", 32'(x0), 32'd0);
    chk("rst_h", 32'(h0), 32'd0);
    chk("rst_pulses", 32'({sp0, pp0}), 32'd0);

    enable = 1'b1;
    @(negedge clk);
    tick();
    chk("first_active", 32'(a0[0]), 32'd1);
    chk("first_x", 32'(x0[7:0]), 32'd160);
    chk("first_h_range", 32'((h0[7:0] >= 8'd7) && (h0[7:0] <= 8'd14)), 32'd1);
    chk("first_spawn_pulse", 32'(sp0), 32'd1);
    @(negedge clk);
    chk("spawn_pulse_one_cycle", 32'(sp0), 32'd0);

    tick_gap(50);
    chk("x_after_50", 32'(x0[7:0]), 32'd110);

    enable = 1'b0;
    @(negedge clk);
    tick_gap(20);
    chk("x_paused", 32'(x0[7:0]), 32'd110);
    enable = 1'b1;
    tick();
    chk("x_tick_on_resume_edge", 32'(x0[7:0]), 32'd110);
    tick();
    chk("x_resumed", 32'(x0[7:0]), 32'd109);
    @(negedge clk);

    tick_gap(106);
    chk("x_at_3", 32'({a0[0], x0[7:0]}), 32'h103);
    chk("d1_single_spawn", 32'(n_sp1), 32'd1);
    speed = 2'd3;
    tick();
    chk("x_3_minus_3", 32'({a0[0], x0[7:0]}), 32'h100);
    @(negedge clk);
    tick();
    chk("slot0_left_zero", 32'(!a0[0] || x0[7:0] != 8'd0), 32'd1);
    chk("d1_respawn", 32'({a1, x1}), 32'h1A0);
    chk("d1_respawn_pulse", 32'(sp1), 32'd1);
    @(negedge clk);
    chk("d1_two_spawns", 32'(n_sp1), 32'd2);

    for (int i = 0; i < 120; i++) begin
      speed = 2'(i % 4);
      tick_gap(1);
    end

    clear = 1'b1;
    obs_tick = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    obs_tick = 1'b0;
    chk("clear_active", 32'({a1, a0}), 32'd0);
    chk("clear_no_spawn", 32'(sp0), 32'd0);
    @(negedge clk);
    speed = 2'd1;
    tick();
    chk("clear_gap_spawn", 32'({sp0, a0[0], x0[7:0]}), 32'h3A0);
    @(negedge clk);

    tick_gap(144);
    chk("x_at_16", 32'(x0[7:0]), 32'd16);
    speed = 2'd2;
    tick();
    chk("x_at_14", 32'(x0[7:0]), 32'd14);
    chk("passed_cross", 32'(pp0), 32'(PP_ON));
    @(negedge clk);
    chk("passed_one_cycle", 32'(pp0), 32'd0);
    tick_gap(10);

    reset = 1'b1;
    @(negedge clk);
    chk("midrun_reset", 32'({a0, x0, h0}), 32'd0);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/obstacle_spawn_scheduler.md
Name: obstacle_spawn_scheduler

Overview:
Sequences the obstacle datapath of the Dino game: moves the obstacle slots left on each obstacle tick, retires slots that leave the screen, and respawns them. Spawn gap and height come from an on-chip LFSR.
Sits between the frame/obstacle tick generators and the collision/pixel-renderer logic, and replaces the fixed two-obstacle update in the game datapath.
Outputs are flat packed slot vectors consumed by the renderer and collision check.

Parameters:
NUM_OBS, 2, number of obstacle slots (1..4)
SPAWN_X, 160, x loaded into a freshly spawned slot (just off-screen right)
MIN_GAP, 40, minimum gap counter reload, in pixels
FIRST_GAP, 0, gap counter value on leaving IDLE
MIN_H, 7, minimum obstacle height; max height is MIN_H+7
DINO_X, 15, dino left edge used for pass detection
LFSR_SEED, 16'hACE1, LFSR value loaded at reset (must be nonzero)

Ports:
clk  in  1  system clock (CLOCK_50 domain)
reset  in  1  synchronous, active-high reset
clear  in  1  level; forces IDLE (game menu / game over restart)
enable  in  1  level; high while the game state is RUNNING
obs_tick  in  1  1-cycle pulse; one movement step
speed  in  2  pixels per tick; 0 is treated as 1
obs_x  out  8*NUM_OBS  slot i x at bits [8i+7:8i]
obs_h  out  8*NUM_OBS  slot i height
obs_active  out  NUM_OBS  slot i valid
spawn_pulse  out  1  1 cycle after a spawn
passed_pulse  out  1  see Optional Feature

Behaviour:
- Reset: obs_x=0, obs_h=0, obs_active=0, spawn_pulse=0, passed_pulse=0, gap=FIRST_GAP, lfsr=LFSR_SEED, state=IDLE.
- LFSR: 16-bit Galois, mask 16'hB400. Advances every clk except during reset. Clear does not affect it.
- FSM:
  - IDLE -> RUN when enable=1.
  - RUN -> HOLD when enable=0.
  - HOLD -> RUN when enable=1.
  - clear=1 in any state -> IDLE next cycle. Clear also sets obs_active=0 and gap=FIRST_GAP. Clear has priority over enable and obs_tick.
- Ticks are acted on only in RUN. In IDLE and HOLD all registers except the LFSR hold (pause freezes the scene).
- On obs_tick in RUN, all updates are registered and visible the following cycle. Let step = max(speed,1).
  - For each active slot: if x < step, the slot retires (active=0, x unchanged); else x <= x - step.
  - Gap: gap <= (gap <= step) ? 0 : gap - step.
  - Spawn: if the pre-tick gap == 0 and a free slot exists, spawn into the lowest-index free slot:
    - x = SPAWN_X
    - h = MIN_H + lfsr[2:0] (range 7..14)
    - gap = MIN_GAP + lfsr[8:3] (range 40..103)
    - spawn_pulse = 1 for one cycle
  - Slots that retire on this tick count as free, so retire and spawn in the same slot on the same tick is legal.
  - A spawned slot is not moved on its spawn tick.
- No free slot while gap==0: gap stays 0 and the spawn is deferred to the first tick on which a slot is free.
- Width rules: the subtract is 8-bit and guarded by the retire test, so it never wraps. gap is 8-bit.
- Reset mid-run behaves identically to power-up. obs_tick coincident with the enable rising edge is ignored (state is still IDLE or HOLD that cycle).

Optional Feature:
Macro OBS_PASS_PULSE_EN.
- Defined: each slot has a passed flag, cleared on spawn.
  - On a tick, an active, unpassed slot whose new x < DINO_X sets its flag.
  - passed_pulse = 1 for one cycle if any slot set its flag that tick; multiple slots in one tick give a single pulse.
  - Retiring slots do not generate the pulse.
- Undefined: passed_pulse tied 0 and no flag registers exist.

Decomposition:
- Shared package: state encodings (IDLE, RUN, HOLD), LFSR mask 16'hB400, and the colour/dimension constants already shared by the game (xMAX, groundTop, obsW).
- One natural sub-module, lfsr16: clk, reset, seed parameter, 16-bit q.
- Per-slot move/retire logic is a generate loop, not a separate module.

Test Plan:
1. Reset, then idle 5 cycles -> obs_active=0, obs_x=0, obs_h=0, no pulses. Then enable=1 and one tick -> slot0 active, x=160, h in 7..14, spawn_pulse for one cycle.
2. Run with speed=1 for 50 ticks after the first spawn -> slot0 x=110; slot1 spawns exactly on the tick after gap (40..103) has counted to 0.
3. enable=0 for 20 ticks mid-run, then enable=1 -> all obs_x, obs_h and gap unchanged across the pause; movement resumes on the next tick.
4. speed=3 with slot0 at x=2 -> retires after one tick. With x=3 -> x=0, then retires on the next tick.
5. NUM_OBS=1, MIN_GAP=8: gap hits 0 while slot0 is at x=100 -> no spawn until slot0 retires. The retire and respawn occur on the same tick, and spawn_pulse is asserted once.
6. clear asserted together with obs_tick in RUN -> next cycle obs_active=0, gap=FIRST_GAP, state IDLE. With OBS_PASS_PULSE_EN, slot0 crossing 16 -> 14 gives exactly one passed_pulse.
